// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO for the E stage.
// The result is computed when the op is accepted and parked in tmp_res.
// It reaches HI/LO only after the modelled latency has elapsed, so the hazard
// unit sees a realistic busy window while the datapath stays single-cycle.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  // keep marks a divide by zero: the busy window runs but HI/LO are left alone
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        keep;
  } res_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  res_t          tmp_res, res;
  logic          is_mul, is_div, accept, commit;
  logic          a_neg, b_neg;
  logic [31:0]   ua, ub, uq, ur;
  logic [63:0]   prod;

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign accept = (state == IDLE) && start && !req &&
                  (op >= OP_MULT) && (op <= OP_MTLO);

  // Single-shot arithmetic; signed divide goes through magnitudes so that
  // 0x80000000 / -1 wraps cleanly to 0x80000000 with a zero remainder.
  always_comb begin
    res   = '0;
    prod  = '0;
    a_neg = (op == OP_DIV) && A[31];
    b_neg = (op == OP_DIV) && B[31];
    ua    = a_neg ? -A : A;
    ub    = b_neg ? -B : B;
    uq    = (ub != 32'd0) ? ua / ub : 32'd0;
    ur    = (ub != 32'd0) ? ua % ub : 32'd0;
    case (op)
      OP_MULT:  prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      OP_MULTU: prod = {32'd0, A} * {32'd0, B};
      default:  prod = '0;
    endcase
    if (is_mul) begin
      res.hi = prod[63:32];
      res.lo = prod[31:0];
    end else if (is_div) begin
      res.keep = (B == 32'd0);
      res.lo   = (a_neg ^ b_neg) ? -uq : uq;
      res.hi   = a_neg ? -ur : ur;
    end
  end

  // State and countdown register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: enter RUN on an accepted mul/div, leave when the count expires
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (is_mul || is_div)) begin
          state_nx = RUN;
          cnt_nx   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs derived from state
  always_comb begin
    busy = (state == RUN);
  end

  // Result parking and architectural HI/LO updates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmp_res <= '0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      if (accept && (is_mul || is_div)) tmp_res <= res;
      if (commit) begin
        if (!tmp_res.keep) begin
          HI <= tmp_res.hi;
          LO <= tmp_res.lo;
        end
      end else if (accept && op == OP_MTHI) begin
        HI <= A;
      end else if (accept && op == OP_MTLO) begin
        LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed and randomized checks of mdu_hilo against a plain-arithmetic model.
module tb_mdu_hilo;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        req = 1'b0;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .req(req), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op; optionally at RUN cycle inj_at drive a stray MTLO and/or a flush.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int inj_at, input logic inj_start,
                        input logic inj_req);
    logic [31:0] eh, el;
    logic [63:0] up;
    longint      sp;
    int          sa, sb, n;
    eh = m_hi; el = m_lo; n = 0;
    sa = a; sb = b;
    case (o)
      3'd1: begin sp = longint'(sa) * longint'(sb); eh = sp[63:32]; el = sp[31:0]; n = MC; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; eh = up[63:32]; el = up[31:0]; n = MC; end
      3'd3: begin
        n = DC;
        if (b != 0) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin el = a; eh = 0; end
          else begin el = sa / sb; eh = sa % sb; end
        end
      end
      3'd4: begin n = DC; if (b != 0) begin el = a / b; eh = a % b; end end
      3'd5: eh = a;
      3'd6: el = a;
      default: ;
    endcase
    start = 1'b1; op = o; A = a; B = b;
    step();
    start = 1'b0; op = 3'd0;
    for (int i = 0; i < n; i++) begin
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
      chk({tag, ".hold_hi"}, HI, m_hi);
      chk({tag, ".hold_lo"}, LO, m_lo);
      if (i == inj_at) begin
        start = inj_start; op = 3'd6; A = 32'hDEADBEEF; req = inj_req;
      end
      step();
      start = 1'b0; op = 3'd0; req = 1'b0;
    end
    chk({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, ".hi"}, HI, eh);
    chk({tag, ".lo"}, LO, el);
    m_hi = eh; m_lo = el;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    // 1: asynchronous reset, then MTHI
    #2 reset = 1'b0;
    #1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.hi", HI, 32'd0);
    chk("rst.lo", LO, 32'd0);
    step();
    reset = 1'b1;
    step();
    run_op("mthi", 3'd5, 32'h12345678, 32'd0, -1, 1'b0, 1'b0);

    // 2: multiplies
    run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, -1, 1'b0, 1'b0);
    chk("mult.hi_const", HI, 32'hFFFFFFFF);
    chk("mult.lo_const", LO, 32'hFFFFFFFA);
    run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, -1, 1'b0, 1'b0);
    chk("multu.hi_const", HI, 32'h00000002);

    // 3: divides
    run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, -1, 1'b0, 1'b0);
    chk("div.lo_const", LO, 32'hFFFFFFFD);
    chk("div.hi_const", HI, 32'hFFFFFFFF);
    run_op("divu", 3'd4, 32'hFFFFFFF9, 32'd2, -1, 1'b0, 1'b0);
    chk("divu.lo_const", LO, 32'h7FFFFFFC);
    chk("divu.hi_const", HI, 32'h00000001);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0, 1'b0);
    chk("div_ovf.lo_const", LO, 32'h80000000);

    // 4: divide by zero leaves HI/LO alone
    run_op("pre_hi", 3'd5, 32'hAAAA0000, 32'd0, -1, 1'b0, 1'b0);
    run_op("pre_lo", 3'd6, 32'h0000BBBB, 32'd0, -1, 1'b0, 1'b0);
    run_op("div0", 3'd3, 32'h1234, 32'd0, -1, 1'b0, 1'b0);
    chk("div0.hi_const", HI, 32'hAAAA0000);
    chk("div0.lo_const", LO, 32'h0000BBBB);

    // 5: flush interactions
    start = 1'b1; op = 3'd1; A = 32'd6; B = 32'd7; req = 1'b1;
    step();
    start = 1'b0; op = 3'd0; req = 1'b0;
    chk("flush.busy", {31'd0, busy}, 32'd0);
    chk("flush.hi", HI, m_hi);
    chk("flush.lo", LO, m_lo);
    run_op("mult_req", 3'd1, 32'd6, 32'd7, 1, 1'b0, 1'b1);
    chk("mult_req.lo_const", LO, 32'd42);
    run_op("mtlo_run", 3'd2, 32'd9, 32'd9, 2, 1'b1, 1'b0);
    run_op("mtlo_run_div", 3'd4, 32'd100, 32'd7, 4, 1'b1, 1'b1);

    // invalid ops do nothing
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; op = (k == 0) ? 3'd0 : 3'd7; A = 32'h55555555;
      step();
      start = 1'b0;
      chk("inv.busy", {31'd0, busy}, 32'd0);
      chk("inv.hi", HI, m_hi);
      chk("inv.lo", LO, m_lo);
    end

    // 6: asynchronous reset mid-divide
    start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
    step();
    start = 1'b0; op = 3'd0;
    step(); step();
    #2 reset = 1'b0;
    #1;
    chk("arst.busy", {31'd0, busy}, 32'd0);
    chk("arst.hi", HI, 32'd0);
    chk("arst.lo", LO, 32'd0);
    m_hi = '0; m_lo = '0;
    #2 reset = 1'b1;
    for (int k = 0; k < DC + 2; k++) begin
      step();
      chk("arst.nolate_hi", HI, 32'd0);
      chk("arst.nolate_lo", LO, 32'd0);
    end
    run_op("post_rst", 3'd1, 32'd3, 32'd4, -1, 1'b0, 1'b0);
    chk("post_rst.lo_const", LO, 32'd12);

    // randomized ops against the model
    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(1, 6));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 5)) * 32'hFFFFFFFF;
      run_op("rand", ro, ra, rb, -1, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits in the E stage, alongside the ALU.
- Its HI/LO values are the data that mfhi/mflo carry down the pipe to the register-file write port.
- Exposes a busy indication so the hazard unit can stall later MD instructions.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  E-stage instruction is an MD op; qualifies op
op  in  3  1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO; others = no-op
A  in  32  rs operand
B  in  32  rt operand
req  in  1  exception/interrupt flush this cycle; suppresses acceptance
busy  out  1  operation in flight
HI  out  32  architectural HI
LO  out  32  architectural LO

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-operation): HI=0, LO=0, busy=0, state=IDLE, counter=0, temp results=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; counter counts down the remaining cycles.
- Acceptance: at a rising edge with state=IDLE, start=1, req=0 and op valid. Nothing is accepted when req=1.
- MULT/MULTU:
  - At acceptance, the 64-bit product is computed and latched into tmp_hi/tmp_lo.
  - MULT treats A and B as two's complement; MULTU treats them as unsigned.
  - Enter RUN with count=MULT_CYCLES.
- DIV/DIVU:
  - At acceptance, tmp_lo=quotient and tmp_hi=remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Enter RUN with count=DIV_CYCLES.
- Divide by zero (B=0):
  - Accepted, and busy runs for DIV_CYCLES.
  - HI/LO are left unchanged at completion.
- RUN timing:
  - busy=1 for exactly N cycles after the accepting edge.
  - Each edge decrements count.
  - At the edge where count reaches 0: HI<=tmp_hi, LO<=tmp_lo, state<=IDLE, busy falls in the same edge.
  - HI/LO hold their old values throughout RUN.
- MTHI/MTLO:
  - Accepted only in IDLE.
  - HI<=A (or LO<=A) at the accepting edge.
  - Does not enter RUN; busy stays 0.
- start=1 while RUN:
  - Ignored. The hazard unit guarantees this does not happen; the block must still not corrupt the in-flight operation.
  - No queueing.
- req=1 during RUN: the in-flight operation completes normally. The flush only blocks new acceptance.
- start with an invalid op (0, 7): no effect.
- Read path:
  - HI/LO are direct register outputs with no bypass.
  - A value written by MTHI at edge k is visible after edge k.
- All arithmetic uses the full 64-bit product. No truncation other than the 32-bit quotient/remainder.

Test Plan:
1. Reset asserted (reset=0) -> HI=0, LO=0, busy=0 immediately, without a clock edge. Release, then MTHI A=0x12345678 -> HI=0x12345678 after one edge, busy stays 0.
2. MULT A=0xFFFFFFFE(-2), B=0x00000003 -> busy high exactly 5 cycles, HI/LO unchanged during those cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0 on the same edge. Repeat as MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
3. DIV A=0xFFFFFFF9(-7), B=0x00000002 -> 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands -> LO=0x7FFFFFFC, HI=0x00000001. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. Preload HI=0xAAAA0000, LO=0x0000BBBB. DIV with B=0 -> busy for 10 cycles, then HI/LO still 0xAAAA0000/0x0000BBBB.
5. Flush interactions:
   - start=1 op=MULT with req=1 -> busy stays 0, HI/LO unchanged.
   - MULT accepted, then req=1 pulsed in cycle 2 -> completes at cycle 5 with the correct product.
   - start=1 op=MTLO during RUN -> LO unaffected except by the completing result.
6. Start DIV, then drive reset=0 asynchronously in cycle 4 -> busy, HI and LO go to 0 at once. After release, no late commit occurs, and the next MULT 3*4 -> LO=12 after 5 cycles.
